// File: rtl/matrix_loader_pkg.sv
// Shared encodings and sizing for the matrix loader: command opcodes,
// controller states and the RAM line geometry.
package matrix_loader_pkg;

    localparam int LINE_BITS  = 256;
    localparam int WORD_BITS  = 32;
    localparam int BEATS      = 8;
    localparam int RD_LATENCY = 2;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_START = 2'b10,
        OP_STOP  = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_COMMIT,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_RD_SEND,
        ST_CORE_RST
    } state_e;

endpackage

// File: rtl/matrix_loader_line_buffer.sv
// One RAM line of storage: write beats shift in from the top so beat 0
// ends up in the low word; read data is loaded whole and shifted out low word first.
module line_buffer
    import matrix_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_in,
    input  logic [WORD_BITS-1:0] word_in,
    input  logic                 load,
    input  logic [LINE_BITS-1:0] line_in,
    input  logic                 shift_out,
    output logic [LINE_BITS-1:0] line_out,
    output logic [WORD_BITS-1:0] word_out
);

    logic [LINE_BITS-1:0] line_q, line_d;

    always_comb begin
        line_d = line_q;
        if (load) begin
            line_d = line_in;
        end else if (shift_in) begin
            line_d = {word_in, line_q[LINE_BITS-1:WORD_BITS]};
        end else if (shift_out) begin
            line_d = {{WORD_BITS{1'b0}}, line_q[LINE_BITS-1:WORD_BITS]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line_out = line_q;
    assign word_out = line_q[WORD_BITS-1:0];

endmodule

// File: rtl/matrix_loader.sv
// Host-command front end for a RAM-backed coprocessor: assembles/serialises
// RAM lines and sequences the coprocessor reset/start controls.
//   state      | meaning
//   IDLE       | accepting commands
//   WR_COMMIT  | one-cycle RAM write of the assembled line
//   RD_ADDR    | RAM address presented
//   RD_WAIT    | RAM read latency
//   RD_SEND    | streaming 8 words to the host
//   CORE_RST   | coprocessor held in reset
module matrix_loader
    import matrix_loader_pkg::*;
#(
    parameter int CORE_RST_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [7:0]           cmd_addr,
    input  logic [31:0]          cmd_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_data,
    output logic                 rsp_last,
    output logic [7:0]           mem_address,
    output logic [LINE_BITS-1:0] mem_data,
    output logic                 mem_wren,
    input  logic [LINE_BITS-1:0] mem_q,
    output logic [1:0]           core_op,
    output logic                 core_start,
    output logic                 core_rst_n,
    output logic                 busy,
    output logic                 err
);

    state_e      state_q, state_d;
    logic [2:0]  beat_q, beat_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic        err_q, err_d;
    logic [1:0]  core_op_q, core_op_d;
    logic        core_start_q, core_start_d;
    logic        core_rst_n_q, core_rst_n_d;
    logic        buf_shift_in, buf_load, buf_shift_out;
    logic [LINE_BITS-1:0] buf_line;
    logic [WORD_BITS-1:0] buf_word;

    line_buffer u_line_buffer (
        .clk       (clk),
        .rst       (rst),
        .shift_in  (buf_shift_in),
        .word_in   (cmd_data),
        .load      (buf_load),
        .line_in   (mem_q),
        .shift_out (buf_shift_out),
        .line_out  (buf_line),
        .word_out  (buf_word)
    );

    always_comb begin
        state_d       = state_q;
        beat_d        = beat_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        err_d         = err_q;
        core_op_d     = core_op_q;
        core_start_d  = core_start_q;
        buf_shift_in  = 1'b0;
        buf_load      = 1'b0;
        buf_shift_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    // Any non-WRITE abandons a partially assembled line.
                    if (cmd_op != OP_WRITE && beat_q != 3'd0) begin
                        err_d  = 1'b1;
                        beat_d = 3'd0;
                    end
                    case (cmd_op)
                        OP_WRITE: begin
                            if (core_start_q) begin
                                err_d = 1'b1;
                            end else begin
                                buf_shift_in = 1'b1;
                                if (beat_q == 3'd0) addr_d = cmd_addr;
                                if (beat_q == 3'(BEATS - 1)) begin
                                    beat_d  = 3'd0;
                                    state_d = ST_WR_COMMIT;
                                end else begin
                                    beat_d = beat_q + 3'd1;
                                end
                            end
                        end
                        OP_READ: begin
                            if (core_start_q) begin
                                err_d = 1'b1;
                            end else begin
                                addr_d  = cmd_addr;
                                state_d = ST_RD_ADDR;
                            end
                        end
                        OP_START: begin
                            core_op_d    = cmd_data[1:0];
                            core_start_d = 1'b1;
                            cnt_d        = 8'(CORE_RST_CYCLES - 1);
                            state_d      = ST_CORE_RST;
                        end
                        OP_STOP: begin
                            core_start_d = 1'b0;
                        end
                    endcase
                end
            end
            ST_WR_COMMIT: state_d = ST_IDLE;
            ST_RD_ADDR: begin
                cnt_d   = 8'(RD_LATENCY - 1);
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (cnt_q == 8'd0) begin
                    buf_load = 1'b1;
                    beat_d   = 3'd0;
                    state_d  = ST_RD_SEND;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RD_SEND: begin
                if (rsp_ready) begin
                    buf_shift_out = 1'b1;
                    if (beat_q == 3'(BEATS - 1)) begin
                        beat_d  = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        beat_d = beat_q + 3'd1;
                    end
                end
            end
            ST_CORE_RST: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        core_rst_n_d = (state_d != ST_CORE_RST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            beat_q       <= 3'd0;
            cnt_q        <= 8'd0;
            addr_q       <= 8'd0;
            err_q        <= 1'b0;
            core_op_q    <= 2'd0;
            core_start_q <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            err_q        <= err_d;
            core_op_q    <= core_op_d;
            core_start_q <= core_start_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // Address is held through the wait states so a registered-address RAM sees it.
    assign mem_address = (state_q == ST_WR_COMMIT || state_q == ST_RD_ADDR ||
                          state_q == ST_RD_WAIT) ? addr_q : 8'd0;
    assign mem_wren    = (state_q == ST_WR_COMMIT);
    assign mem_data    = (state_q == ST_WR_COMMIT) ? buf_line : '0;
    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign rsp_valid   = (state_q == ST_RD_SEND);
    assign rsp_data    = (state_q == ST_RD_SEND) ? buf_word : 32'd0;
    assign rsp_last    = (state_q == ST_RD_SEND) && (beat_q == 3'(BEATS - 1));
    assign err         = err_q;
    assign core_op     = core_op_q;
    assign core_start  = core_start_q;
    assign core_rst_n  = core_rst_n_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader: write/read/start/stop/error/reset scenarios
// against hand-computed expected values.
module tb_matrix_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [7:0]   cmd_addr;
    logic [31:0]  cmd_data;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [31:0]  rsp_data;
    logic         rsp_last;
    logic [7:0]   mem_address;
    logic [255:0] mem_data;
    logic         mem_wren;
    logic [255:0] mem_q;
    logic [1:0]   core_op;
    logic         core_start;
    logic         core_rst_n;
    logic         busy;
    logic         err;

    int tests = 0;
    int fails = 0;
    int wren_cnt = 0;
    int rsp_beats = 0;
    logic [255:0] pat;
    logic [255:0] exp_line;

    always #5 clk = ~clk;

    assign mem_q = (mem_address == 8'd2) ? pat : '0;

    matrix_loader #(.CORE_RST_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_last(rsp_last),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q),
        .core_op(core_op), .core_start(core_start), .core_rst_n(core_rst_n),
        .busy(busy), .err(err)
    );

    always @(negedge clk) begin
        if (mem_wren) wren_cnt++;
        if (rsp_valid && rsp_ready) rsp_beats++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string p);
        chk({p, "_cmd_ready"},   cmd_ready,   1);
        chk({p, "_rsp_valid"},   rsp_valid,   0);
        chk({p, "_rsp_last"},    rsp_last,    0);
        chk({p, "_rsp_data"},    rsp_data,    0);
        chk({p, "_mem_wren"},    mem_wren,    0);
        chk({p, "_mem_address"}, mem_address, 0);
        chk({p, "_mem_data"},    mem_data,    0);
        chk({p, "_core_start"},  core_start,  0);
        chk({p, "_core_op"},     core_op,     0);
        chk({p, "_core_rst_n"},  core_rst_n,  0);
        chk({p, "_busy"},        busy,        0);
        chk({p, "_err"},         err,         0);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && n < 100) begin
            tick();
            n++;
        end
        chk("cmd_accept_in_time", n < 100, 1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = 8'd0;
        cmd_data  = 32'd0;
    endtask

    task automatic wait_rsp(input int exp_wait, input string tag);
        int n = 0;
        while (!rsp_valid && n < 20) begin
            tick();
            n++;
        end
        chk(tag, n, exp_wait);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 8; k++) begin
            pat[32*k +: 32] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
        end
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'd0;
        cmd_data = 32'd0; rsp_ready = 1'b0;
        tick(); tick(); tick();
        chk_reset("reset");
        rst = 1'b1;
        tick();
        chk("rst_n_first_edge", core_rst_n, 1);

        // 8 WRITEs to address 1; later beats carry a different address that must be ignored
        for (int k = 0; k < 8; k++) begin
            send(2'b00, (k == 0) ? 8'd1 : 8'hAA, 32'(k + 1));
            exp_line[32*k +: 32] = 32'(k + 1);
        end
        chk("wr_commit_wren", mem_wren, 1);
        chk("wr_commit_addr", mem_address, 8'd1);
        chk("wr_commit_data", mem_data, exp_line);
        chk("wr_commit_low_word", mem_data[31:0], 32'd1);
        chk("wr_commit_ready", cmd_ready, 0);
        tick();
        chk("wr_after_wren", mem_wren, 0);
        chk("wr_after_addr", mem_address, 0);
        chk("wr_after_ready", cmd_ready, 1);
        chk("wr_pulse_count", wren_cnt, 1);

        // READ address 2 with rsp_ready toggling
        send(2'b01, 8'd2, 32'd0);
        chk("rd_addr_drive", mem_address, 8'd2);
        chk("rd_busy", busy, 1);
        wait_rsp(3, "rd_latency");
        for (int b = 0; b < 8; b++) begin
            rsp_ready = 1'b0;
            chk($sformatf("rd_valid_%0d", b), rsp_valid, 1);
            chk($sformatf("rd_data_%0d", b), rsp_data, pat[32*b +: 32]);
            chk($sformatf("rd_last_%0d", b), rsp_last, (b == 7));
            tick();
            chk($sformatf("rd_stall_data_%0d", b), rsp_data, pat[32*b +: 32]);
            rsp_ready = 1'b1;
            tick();
        end
        rsp_ready = 1'b0;
        chk("rd_done_valid", rsp_valid, 0);
        chk("rd_done_busy", busy, 0);
        chk("rd_beat_count", rsp_beats, 8);

        // START with data 2, then WRITE while started, then STOP
        send(2'b10, 8'd0, 32'd2);
        chk("start_core_op", core_op, 2'd2);
        chk("start_core_start", core_start, 1);
        n = 0;
        while (!core_rst_n && n < 50) begin
            n++;
            tick();
        end
        chk("start_rst_low_cycles", n, 8);
        chk("start_held", core_start, 1);
        chk("start_idle", busy, 0);
        chk("started_err_clear", err, 0);
        send(2'b00, 8'd5, 32'h1234);
        chk("started_wr_err", err, 1);
        chk("started_wr_ready", cmd_ready, 1);
        tick();
        chk("started_wr_no_wren", wren_cnt, 1);
        send(2'b11, 8'd0, 32'd0);
        chk("stop_core_start", core_start, 0);
        chk("stop_core_op_kept", core_op, 2'd2);
        chk("stop_idle", busy, 0);

        // reset clears sticky err
        rst = 1'b0;
        tick();
        chk_reset("reset2");
        rst = 1'b1;
        tick();

        // 3 WRITE beats then READ: partial line discarded
        for (int k = 0; k < 3; k++) send(2'b00, 8'd7, 32'hA0 + 32'(k));
        chk("partial_err_clear", err, 0);
        send(2'b01, 8'd2, 32'd0);
        chk("partial_read_err", err, 1);
        rsp_ready = 1'b1;
        n = rsp_beats;
        wait_rsp(3, "partial_rd_latency");
        for (int b = 0; b < 8; b++) begin
            chk($sformatf("partial_rd_data_%0d", b), rsp_data, pat[32*b +: 32]);
            tick();
        end
        rsp_ready = 1'b0;
        chk("partial_rd_beats", rsp_beats - n, 8);
        chk("partial_no_wren", wren_cnt, 1);
        for (int k = 0; k < 8; k++) begin
            send(2'b00, (k == 0) ? 8'd9 : 8'd3, 32'h100 + 32'(k));
            exp_line[32*k +: 32] = 32'h100 + 32'(k);
        end
        chk("fresh_wren", mem_wren, 1);
        chk("fresh_addr", mem_address, 8'd9);
        chk("fresh_data", mem_data, exp_line);
        tick();
        chk("fresh_pulse_count", wren_cnt, 2);

        // reset during RD_SEND at beat 3
        send(2'b01, 8'd2, 32'd0);
        wait_rsp(3, "abort_rd_latency");
        rsp_ready = 1'b1;
        tick(); tick(); tick();
        rsp_ready = 1'b0;
        chk("abort_beat3_data", rsp_data, pat[96 +: 32]);
        n = rsp_beats;
        rst = 1'b0;
        tick();
        chk_reset("abort");
        rst = 1'b1;
        rsp_ready = 1'b1;
        tick(); tick(); tick();
        chk("abort_no_valid", rsp_valid, 0);
        chk("abort_no_beats", rsp_beats - n, 0);
        chk("abort_no_wren", wren_cnt, 2);
        rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
